// File: rtl/l1d_top_if.sv
// ============================================================
// Module : l1d_top_if
// Upstream request/ack and downstream refill/evict bus bundle.
// Revision: 1.0
// ============================================================
`default_nettype none

interface l1d_top_if;
  logic        upstream_req_vld;
  logic        upstream_req_rdy;
  logic [64:0] upstream_req_pld;
  logic        cancel_last_trans;
  logic        clear_mshr_rd;
  logic        upstream_tag_hit;
  logic        upstream_ack_en;
  logic [31:0] upstream_ack_dat;
  logic [64:0] upstream_sb_pld;
  logic        downstream_req_vld;
  logic        downstream_req_rdy;
  logic [29:0] downstream_req_pld;
  logic [1:0]  downstream_req_id;
  logic        downstream_rsp_vld;
  logic        downstream_rsp_rdy;
  logic [31:0] downstream_rsp_pld;
  logic [1:0]  downstream_rsp_id;
  logic        downstream_evict_vld;
  logic        downstream_evict_rdy;
  logic [61:0] downstream_evict_pld;

  // Environment side: issues upstream requests, answers downstream traffic
  modport master (
    output upstream_req_vld, upstream_req_pld, cancel_last_trans, clear_mshr_rd,
           downstream_req_rdy, downstream_rsp_vld, downstream_rsp_pld, downstream_rsp_id,
           downstream_evict_rdy,
    input  upstream_req_rdy, upstream_tag_hit, upstream_ack_en, upstream_ack_dat,
           upstream_sb_pld, downstream_req_vld, downstream_req_pld, downstream_req_id,
           downstream_rsp_rdy, downstream_evict_vld, downstream_evict_pld
  );

  // Cache side
  modport slave (
    input  upstream_req_vld, upstream_req_pld, cancel_last_trans, clear_mshr_rd,
           downstream_req_rdy, downstream_rsp_vld, downstream_rsp_pld, downstream_rsp_id,
           downstream_evict_rdy,
    output upstream_req_rdy, upstream_tag_hit, upstream_ack_en, upstream_ack_dat,
           upstream_sb_pld, downstream_req_vld, downstream_req_pld, downstream_req_id,
           downstream_rsp_rdy, downstream_evict_vld, downstream_evict_pld
  );
endinterface

`default_nettype wire

// File: rtl/l1d_top.sv
// ============================================================
// Module : l1d_top
// Direct-mapped 16-line write-back/write-allocate L1D, one miss at a time.
// Option : L1D_SB_PLD_EN exports the last committed store on upstream_sb_pld.
// Revision: 1.0
// ============================================================
`default_nettype none

module l1d_top (
  input  logic     clk,
  input  logic     rst_n,
  l1d_top_if.slave bus
);
  localparam int c_LINES = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, EVICT = 2'd1, REQ = 2'd2, WAIT = 2'd3} state_t;

  state_t      r_state, w_state_nxt;

  logic        r_lk_vld, r_lk_op;
  logic [31:0] r_lk_addr, r_lk_wdata;
  logic        r_ms_op;
  logic [31:0] r_ms_addr, r_ms_wdata;
  logic [1:0]  r_id_cnt, r_wait_id;
  logic        r_clr_seen;
  logic        r_ack_en;
  logic [31:0] r_ack_dat;

  logic [c_LINES-1:0] r_valid, r_dirty;
  logic [25:0]        r_tag  [c_LINES];
  logic [31:0]        r_data [c_LINES];

  logic [3:0]  w_lk_idx, w_ms_idx;
  logic        w_lk_live, w_lk_hit, w_lk_miss, w_victim_dirty;
  logic        w_accept, w_evict_done, w_req_done, w_rsp_match;
  logic        w_wr_en, w_wr_dirty;
  logic [31:0] w_wr_addr, w_wr_data;

  assign w_lk_idx       = r_lk_addr[5:2];
  assign w_ms_idx       = r_ms_addr[5:2];
  assign w_lk_live      = r_lk_vld && !bus.cancel_last_trans;
  assign w_lk_hit       = w_lk_live && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == r_lk_addr[31:6]);
  assign w_lk_miss      = w_lk_live && !w_lk_hit;
  assign w_victim_dirty = r_valid[w_lk_idx] && r_dirty[w_lk_idx];
  assign w_accept       = bus.upstream_req_vld && bus.upstream_req_rdy;
  assign w_evict_done   = (r_state == EVICT) && bus.downstream_evict_rdy;
  assign w_req_done     = (r_state == REQ) && bus.downstream_req_rdy;
  assign w_rsp_match    = (r_state == WAIT) && bus.downstream_rsp_vld
                          && (bus.downstream_rsp_id == r_wait_id);

  assign bus.upstream_tag_hit = w_lk_hit;
  assign bus.upstream_ack_en  = w_lk_hit || r_ack_en;
  assign bus.upstream_ack_dat = w_lk_hit ? (r_lk_op ? 32'd0 : r_data[w_lk_idx])
                                         : (r_ack_en ? r_ack_dat : 32'd0);
  assign bus.downstream_req_id = r_id_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt              = r_state;
    bus.upstream_req_rdy     = 1'b0;
    bus.downstream_req_vld   = 1'b0;
    bus.downstream_req_pld   = '0;
    bus.downstream_rsp_rdy   = 1'b0;
    bus.downstream_evict_vld = 1'b0;
    bus.downstream_evict_pld = '0;
    case (r_state)
      IDLE: begin
        bus.upstream_req_rdy = !r_lk_vld && !rst_n;
        if (w_lk_miss) begin
          if (w_victim_dirty) w_state_nxt = EVICT;
          else if (!r_lk_op)  w_state_nxt = REQ;
        end
      end
      EVICT: begin
        bus.downstream_evict_vld = 1'b1;
        bus.downstream_evict_pld = {r_tag[w_ms_idx], w_ms_idx, r_data[w_ms_idx]};
        if (bus.downstream_evict_rdy) w_state_nxt = r_ms_op ? IDLE : REQ;
      end
      REQ: begin
        bus.downstream_req_vld = 1'b1;
        bus.downstream_req_pld = r_ms_addr[31:2];
        if (bus.downstream_req_rdy) w_state_nxt = WAIT;
      end
      WAIT: begin
        bus.downstream_rsp_rdy = 1'b1;
        if (w_rsp_match) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Single array write port: store hit / clean store miss, store after eviction, refill
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_dirty = 1'b1;
    w_wr_addr  = r_lk_addr;
    w_wr_data  = r_lk_wdata;
    if (w_lk_live && r_lk_op && (w_lk_hit || !w_victim_dirty)) begin
      w_wr_en = 1'b1;
    end else if (w_evict_done && r_ms_op) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_ms_addr;
      w_wr_data = r_ms_wdata;
    end else if (w_rsp_match) begin
      w_wr_en    = 1'b1;
      w_wr_dirty = 1'b0;
      w_wr_addr  = r_ms_addr;
      w_wr_data  = bus.downstream_rsp_pld;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_lk_vld   <= 1'b0;
      r_lk_op    <= 1'b0;
      r_lk_addr  <= '0;
      r_lk_wdata <= '0;
      r_ms_op    <= 1'b0;
      r_ms_addr  <= '0;
      r_ms_wdata <= '0;
      r_id_cnt   <= '0;
      r_wait_id  <= '0;
      r_clr_seen <= 1'b0;
      r_ack_en   <= 1'b0;
      r_ack_dat  <= '0;
      r_valid    <= '0;
      r_dirty    <= '0;
      for (int i = 0; i < c_LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_ack_en <= 1'b0;
      r_lk_vld <= w_accept;
      if (w_accept) begin
        r_lk_op    <= bus.upstream_req_pld[64];
        r_lk_addr  <= bus.upstream_req_pld[63:32];
        r_lk_wdata <= bus.upstream_req_pld[31:0];
      end
      if (w_lk_miss) begin
        r_ms_op    <= r_lk_op;
        r_ms_addr  <= r_lk_addr;
        r_ms_wdata <= r_lk_wdata;
        if (r_lk_op && !w_victim_dirty) r_ack_en <= 1'b1;
      end
      if (w_evict_done && r_ms_op) r_ack_en <= 1'b1;
      if (w_req_done) begin
        r_wait_id  <= r_id_cnt;
        r_id_cnt   <= r_id_cnt + 2'd1;
        r_clr_seen <= 1'b0;
      end else if ((r_state == WAIT) && bus.clear_mshr_rd) begin
        r_clr_seen <= 1'b1;
      end
      // A clear in the response cycle itself also suppresses the ack
      if (w_rsp_match) begin
        r_ack_en  <= !(r_clr_seen || bus.clear_mshr_rd);
        r_ack_dat <= bus.downstream_rsp_pld;
      end
      if (w_wr_en) begin
        r_valid[w_wr_addr[5:2]] <= 1'b1;
        r_dirty[w_wr_addr[5:2]] <= w_wr_dirty;
        r_tag[w_wr_addr[5:2]]   <= w_wr_addr[31:6];
        r_data[w_wr_addr[5:2]]  <= w_wr_data;
      end
    end
  end

`ifdef L1D_SB_PLD_EN
  logic [64:0] r_sb_pld;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                        r_sb_pld <= '0;
    else if (w_wr_en && w_wr_dirty)   r_sb_pld <= {1'b1, w_wr_addr, w_wr_data};
  end
  assign bus.upstream_sb_pld = r_sb_pld;
`else
  logic w_unused_ok;
  assign w_unused_ok         = ^w_wr_addr[1:0];
  assign bus.upstream_sb_pld = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1d_top.sv
// ============================================================
// Module : tb_l1d_top
// Directed + randomized bench for l1d_top against a line-array cache model.
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_l1d_top;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  l1d_top_if bus();
  l1d_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef L1D_SB_PLD_EN
  localparam bit c_SB_EN = 1'b1;
`else
  localparam bit c_SB_EN = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cache contents, next expected refill id, last committed store
  bit          mv[16];
  bit          md[16];
  logic [25:0] mt[16];
  logic [31:0] mdat[16];
  logic [1:0]  mid;
  logic [64:0] msb;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
      mdat[i] = '0;
    end
    mid = 2'd0;
    msb = '0;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_req_rdy"},   96'(bus.upstream_req_rdy), 96'(0));
    chk({t, "_tag_hit"},   96'(bus.upstream_tag_hit), 96'(0));
    chk({t, "_ack_en"},    96'(bus.upstream_ack_en), 96'(0));
    chk({t, "_ack_dat"},   96'(bus.upstream_ack_dat), 96'(0));
    chk({t, "_sb_pld"},    96'(bus.upstream_sb_pld), 96'(0));
    chk({t, "_dreq_vld"},  96'(bus.downstream_req_vld), 96'(0));
    chk({t, "_dreq_pld"},  96'(bus.downstream_req_pld), 96'(0));
    chk({t, "_dreq_id"},   96'(bus.downstream_req_id), 96'(0));
    chk({t, "_rsp_rdy"},   96'(bus.downstream_rsp_rdy), 96'(0));
    chk({t, "_ev_vld"},    96'(bus.downstream_evict_vld), 96'(0));
    chk({t, "_ev_pld"},    96'(bus.downstream_evict_pld), 96'(0));
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (bus.upstream_req_rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_rdy_idle", 96'(bus.upstream_req_rdy), 96'(1));
  endtask

  task automatic do_txn(input bit op, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit cancel, input bit clr, input bit bad_id,
                        input int ev_stall, input int req_stall, input logic [31:0] rsp_data);
    logic [3:0]  idx;
    logic [25:0] tg;
    logic [61:0] ev;
    logic [1:0]  eid;
    bit          hit;
    bit          vdirty;
    idx = addr[5:2];
    tg  = addr[31:6];
    wait_rdy();
    bus.upstream_req_vld = 1'b1;
    bus.upstream_req_pld = {op, addr, wdata};
    tick();
    bus.upstream_req_vld = 1'b0;
    bus.upstream_req_pld = '0;
    chk("req_rdy_lookup", 96'(bus.upstream_req_rdy), 96'(0));
    bus.cancel_last_trans = cancel;
    #1;
    hit = mv[idx] && (mt[idx] == tg);
    chk("tag_hit", 96'(bus.upstream_tag_hit), 96'(!cancel && hit));
    if (cancel) begin
      chk("ack_cancel", 96'(bus.upstream_ack_en), 96'(0));
      tick();
      bus.cancel_last_trans = 1'b0;
      chk("dreq_cancel", 96'(bus.downstream_req_vld), 96'(0));
      chk("evict_cancel", 96'(bus.downstream_evict_vld), 96'(0));
      chk("ack_after_cancel", 96'(bus.upstream_ack_en), 96'(0));
    end else if (hit) begin
      chk("hit_ack_en", 96'(bus.upstream_ack_en), 96'(1));
      chk("hit_ack_dat", 96'(bus.upstream_ack_dat), 96'(op ? 32'd0 : mdat[idx]));
      if (op) begin
        mdat[idx] = wdata;
        md[idx] = 1'b1;
        msb = {1'b1, addr, wdata};
      end
      tick();
      chk("hit_ack_pulse", 96'(bus.upstream_ack_en), 96'(0));
    end else begin
      chk("miss_ack_en", 96'(bus.upstream_ack_en), 96'(0));
      vdirty = mv[idx] && md[idx];
      tick();
      chk("evict_vld", 96'(bus.downstream_evict_vld), 96'(vdirty));
      if (vdirty) begin
        ev = {mt[idx], idx, mdat[idx]};
        for (int i = 0; i < ev_stall; i++) begin
          chk("evict_pld_hold", 96'(bus.downstream_evict_pld), 96'(ev));
          tick();
        end
        chk("evict_pld", 96'(bus.downstream_evict_pld), 96'(ev));
        chk("dreq_before_evict", 96'(bus.downstream_req_vld), 96'(0));
        bus.downstream_evict_rdy = 1'b1;
        tick();
        bus.downstream_evict_rdy = 1'b0;
      end
      if (op) begin
        mv[idx] = 1'b1; md[idx] = 1'b1; mt[idx] = tg; mdat[idx] = wdata;
        msb = {1'b1, addr, wdata};
        chk("st_miss_ack_en", 96'(bus.upstream_ack_en), 96'(1));
        tick();
        chk("st_miss_ack_pulse", 96'(bus.upstream_ack_en), 96'(0));
      end else begin
        eid = mid;
        chk("dreq_vld", 96'(bus.downstream_req_vld), 96'(1));
        for (int i = 0; i < req_stall; i++) begin
          chk("dreq_pld_hold", 96'(bus.downstream_req_pld), 96'(addr[31:2]));
          chk("dreq_vld_hold", 96'(bus.downstream_req_vld), 96'(1));
          chk("req_rdy_stall", 96'(bus.upstream_req_rdy), 96'(0));
          tick();
        end
        chk("dreq_pld", 96'(bus.downstream_req_pld), 96'(addr[31:2]));
        chk("dreq_id", 96'(bus.downstream_req_id), 96'(eid));
        bus.downstream_req_rdy = 1'b1;
        tick();
        bus.downstream_req_rdy = 1'b0;
        mid = mid + 2'd1;
        chk("rsp_rdy_wait", 96'(bus.downstream_rsp_rdy), 96'(1));
        chk("dreq_vld_wait", 96'(bus.downstream_req_vld), 96'(0));
        if (bad_id) begin
          bus.downstream_rsp_vld = 1'b1;
          bus.downstream_rsp_id  = eid + 2'd1;
          bus.downstream_rsp_pld = ~rsp_data;
          tick();
          bus.downstream_rsp_vld = 1'b0;
          chk("bad_id_no_ack", 96'(bus.upstream_ack_en), 96'(0));
          chk("bad_id_still_wait", 96'(bus.downstream_rsp_rdy), 96'(1));
        end
        if (clr) begin
          bus.clear_mshr_rd = 1'b1;
          tick();
          bus.clear_mshr_rd = 1'b0;
        end
        bus.downstream_rsp_vld = 1'b1;
        bus.downstream_rsp_id  = eid;
        bus.downstream_rsp_pld = rsp_data;
        tick();
        bus.downstream_rsp_vld = 1'b0;
        bus.downstream_rsp_pld = '0;
        mv[idx] = 1'b1; md[idx] = 1'b0; mt[idx] = tg; mdat[idx] = rsp_data;
        chk("refill_ack_en", 96'(bus.upstream_ack_en), 96'(!clr));
        if (!clr) chk("refill_ack_dat", 96'(bus.upstream_ack_dat), 96'(rsp_data));
        chk("rsp_rdy_idle", 96'(bus.downstream_rsp_rdy), 96'(0));
        tick();
        chk("refill_ack_pulse", 96'(bus.upstream_ack_en), 96'(0));
      end
    end
    chk("sb_pld", 96'(bus.upstream_sb_pld), 96'(c_SB_EN ? msb : 65'd0));
  endtask

  initial begin
    logic [31:0] a;
    bit          op;
    bus.upstream_req_vld     = 1'b0;
    bus.upstream_req_pld     = '0;
    bus.cancel_last_trans    = 1'b0;
    bus.clear_mshr_rd        = 1'b0;
    bus.downstream_req_rdy   = 1'b0;
    bus.downstream_rsp_vld   = 1'b0;
    bus.downstream_rsp_pld   = '0;
    bus.downstream_rsp_id    = '0;
    bus.downstream_evict_rdy = 1'b0;
    reset_model();

    // Reset state
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b0;
    tick();

    // Load miss on empty cache, then repeat load hits
    do_txn(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 32'hDEADBEEF);
    do_txn(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    // Store hit, then conflicting load forces dirty eviction
    do_txn(1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    do_txn(1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 2, 0, 32'hCAFEF00D);
    // Cancelled lookup
    do_txn(1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
    // clear_mshr_rd during WAIT, then the line hits
    do_txn(1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h11112222);
    do_txn(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    // Mismatched-id response discarded
    do_txn(1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h55AA55AA);
    // Refill request stalled for 5 cycles
    do_txn(1'b0, 32'h48, 32'h0, 1'b0, 1'b0, 1'b0, 0, 5, 32'h0BADCAFE);
    // Store miss on a clean victim
    do_txn(1'b1, 32'h4C, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);

    // Reset while a refill request is outstanding
    wait_rdy();
    bus.upstream_req_vld = 1'b1;
    bus.upstream_req_pld = {1'b0, 32'h3C0, 32'h0};
    tick();
    bus.upstream_req_vld = 1'b0;
    bus.upstream_req_pld = '0;
    tick();
    chk("pre_rst_dreq_vld", 96'(bus.downstream_req_vld), 96'(1));
    #2;
    rst_n = 1'b1;
    #1;
    chk_zero("mid_reset");
    tick();
    rst_n = 1'b0;
    reset_model();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_ack", 96'(bus.upstream_ack_en), 96'(0));
      chk("post_rst_dreq", 96'(bus.downstream_req_vld), 96'(0));
    end
    do_txn(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h77778888);

    // Randomized traffic over a few tags per index to mix hits, conflicts and evictions
    for (int n = 0; n < 200; n++) begin
      a  = {(($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'($urandom_range(0, 3))),
            4'($urandom_range(0, 15)), 2'b00};
      op = 1'($urandom_range(0, 1));
      do_txn(op, a, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 4) == 0), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
